// File: rtl/arbiter_pkg.sv
// Shared types and constants for the arbiter event stream.
// Packet layout, window sizing and decoder state encoding.
package arbiter_pkg;

  localparam int ROWS       = 8;
  localparam int COLS       = 8;
  localparam int ROW_ADD    = 3;
  localparam int COL_ADD    = 3;
  localparam int SIZE       = 32;
  localparam int WIDTH      = SIZE + ROW_ADD + COL_ADD + 1;
  localparam int FIFO_DEPTH = 4;
  localparam int WIN_BITS   = 10;
  localparam int WIN_W      = SIZE - WIN_BITS;

  localparam int TS_LSB  = 7;
  localparam int ROW_LSB = 4;
  localparam int COL_LSB = 1;
  localparam int POL_BIT = 0;

  typedef struct packed {
    logic [SIZE-1:0]    ts;
    logic [ROW_ADD-1:0] row;
    logic [COL_ADD-1:0] col;
    logic               pol;
  } event_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    CLEAR
  } dec_state_e;

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO buffering incoming event packets.
// A full FIFO refuses a push even if a pop happens in the same cycle.
module event_fifo
  import arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/event_packet_decoder.sv
// Event stream receiver: windowed ON/OFF hit map per pixel,
// drained row by row to the frame consumer when a window closes.
module event_packet_decoder
  import arbiter_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                pkt_valid_i,
  input  logic [WIDTH-1:0]    pkt_data_i,
  output logic                pkt_ready_o,
  input  logic                flush_i,
  output logic                frame_valid_o,
  output logic [2*COLS-1:0]   frame_row_o,
  output logic [ROW_ADD-1:0]  frame_idx_o,
  output logic [SIZE-1:0]     frame_ts_o,
  input  logic                frame_ready_i,
  output logic                ts_err_o,
  output logic [15:0]         drop_cnt_o
);

  dec_state_e state;
  dec_state_e state_nx;

  logic [WIDTH-1:0]          head_raw;
  event_pkt_t                head;
  logic                      full;
  logic                      empty;
  logic                      pop;
  logic [WIN_W-1:0]          cur_win;
  logic [WIN_W-1:0]          head_win;
  logic [ROWS-1:0][2*COLS-1:0] map;
  logic [ROW_ADD-1:0]        row_cnt;
  logic                      addr_ok;
  logic                      last_row;
  logic                      beat_done;
  logic                      load_win;
  logic                      set_hit;
  logic                      drop;
  logic                      clr_map;

  event_fifo u_fifo (
    .clk   (clk_i),
    .reset (reset_i),
    .push  (pkt_valid_i),
    .pop   (pop),
    .din   (pkt_data_i),
    .full  (full),
    .empty (empty),
    .head  (head_raw)
  );

  assign head        = event_pkt_t'(head_raw);
  assign head_win    = head.ts[SIZE-1:WIN_BITS];
  assign pkt_ready_o = !full;
  assign addr_ok     = (int'(head.row) < ROWS) && (int'(head.col) < COLS);
  assign last_row    = (row_cnt == ROW_ADD'(ROWS-1));
  assign beat_done   = (state == DRAIN) && frame_ready_i;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load_win = 1'b0;
    set_hit  = 1'b0;
    drop     = 1'b0;
    clr_map  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          load_win = 1'b1;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        if (flush_i) begin
          state_nx = DRAIN;
        end else if (!empty) begin
          // A newer window closes the current one; the packet waits.
          if (head_win > cur_win) begin
            state_nx = DRAIN;
          end else begin
            pop = 1'b1;
            if (head_win == cur_win && addr_ok) set_hit = 1'b1;
            else drop = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (beat_done && last_row) state_nx = CLEAR;
      end
      CLEAR: begin
        clr_map = 1'b1;
        if (!empty) begin
          load_win = 1'b1;
          state_nx = ACCUM;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      cur_win    <= '0;
      map        <= '0;
      row_cnt    <= '0;
      ts_err_o   <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      state    <= state_nx;
      ts_err_o <= drop;
      if (load_win) cur_win <= head_win;
      if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      // Pixel c: bit 2c is the ON hit, bit 2c+1 the OFF hit.
      if (clr_map) map <= '0;
      else if (set_hit) map[head.row][{head.col, ~head.pol}] <= 1'b1;
      if (beat_done) row_cnt <= last_row ? '0 : row_cnt + ROW_ADD'(1);
    end
  end

  assign frame_valid_o = (state == DRAIN);
  assign frame_idx_o   = row_cnt;
  assign frame_row_o   = frame_valid_o ? map[row_cnt] : '0;
  assign frame_ts_o    = frame_valid_o ? {cur_win, {WIN_BITS{1'b0}}} : '0;

endmodule

// File: tb/tb_event_packet_decoder.sv
// Scoreboard bench for event_packet_decoder: a window/hit-map
// reference model predicts frame beats and drop pulses.
module tb_event_packet_decoder;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        pkt_valid_i = 1'b0;
  logic [38:0] pkt_data_i = '0;
  logic        pkt_ready_o;
  logic        flush_i;
  logic        frame_valid_o;
  logic [15:0] frame_row_o;
  logic [2:0]  frame_idx_o;
  logic [31:0] frame_ts_o;
  logic        frame_ready_i = 1'b0;
  logic        ts_err_o;
  logic [15:0] drop_cnt_o;

  event_packet_decoder dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .pkt_valid_i   (pkt_valid_i),
    .pkt_data_i    (pkt_data_i),
    .pkt_ready_o   (pkt_ready_o),
    .flush_i       (flush_i),
    .frame_valid_o (frame_valid_o),
    .frame_row_o   (frame_row_o),
    .frame_idx_o   (frame_idx_o),
    .frame_ts_o    (frame_ts_o),
    .frame_ready_i (frame_ready_i),
    .ts_err_o      (ts_err_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] row;
    logic [31:0] ts;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] drop_q[$];
  logic [38:0] tx_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int err_seen = 0;
  int vprob = 100;
  bit rmode = 1'b0;
  bit rforce = 1'b1;

  bit          m_active;
  int unsigned m_cur;
  bit          m_on[8][8];
  bit          m_off[8][8];
  int          m_drops;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [38:0] mk(input logic [31:0] ts, input int r,
                                     input int c, input bit p);
    return {ts, 3'(r), 3'(c), p};
  endfunction

  function automatic void m_clear_map();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        m_on[r][c] = 1'b0;
        m_off[r][c] = 1'b0;
      end
  endfunction

  function automatic void m_emit();
    beat_t b;
    for (int r = 0; r < 8; r++) begin
      b.idx = 3'(r);
      b.ts = m_cur * 1024;
      b.row = '0;
      for (int c = 0; c < 8; c++) begin
        b.row[2*c] = m_on[r][c];
        b.row[2*c+1] = m_off[r][c];
      end
      exp_q.push_back(b);
    end
    m_clear_map();
  endfunction

  function automatic void m_accept(input logic [38:0] p);
    int unsigned ts, w;
    int r, c;
    ts = p[38:7];
    r = int'(p[6:4]);
    c = int'(p[3:1]);
    w = ts / 1024;
    if (!m_active) begin
      m_active = 1'b1;
      m_cur = w;
    end else if (w > m_cur) begin
      m_emit();
      m_cur = w;
    end
    if (w < m_cur || r >= 8 || c >= 8) begin
      if (m_drops < 65535) m_drops++;
      drop_q.push_back(16'(m_drops));
    end else if (p[0]) begin
      m_on[r][c] = 1'b1;
    end else begin
      m_off[r][c] = 1'b1;
    end
  endfunction

  function automatic void m_flush();
    if (m_active) begin
      m_emit();
      m_active = 1'b0;
    end
  endfunction

  function automatic void m_reset();
    exp_q.delete();
    drop_q.delete();
    tx_q.delete();
    m_active = 1'b0;
    m_cur = 0;
    m_drops = 0;
    m_clear_map();
  endfunction

  // Packet driver: presents the head of tx_q, with optional gaps.
  always @(posedge clk) begin
    #1;
    if (tx_q.size() != 0 && $urandom_range(99) < vprob) begin
      pkt_valid_i = 1'b1;
      pkt_data_i = tx_q[0];
    end else begin
      pkt_valid_i = 1'b0;
    end
    frame_ready_i = rmode ? ($urandom_range(3) != 0) : rforce;
  end

  // Monitor: feeds accepted packets to the model, checks beats/drops.
  always @(negedge clk) begin
    beat_t b;
    if (!reset_i) begin
      if (pkt_valid_i && pkt_ready_o) begin
        m_accept(pkt_data_i);
        acc_cnt++;
        void'(tx_q.pop_front());
      end
      if (frame_valid_o && frame_ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL beat_unexpected: got idx %0d row %0h, none expected",
                   frame_idx_o, frame_row_o);
        end else begin
          b = exp_q.pop_front();
          chk("beat_idx", 64'(frame_idx_o), 64'(b.idx));
          chk("beat_row", 64'(frame_row_o), 64'(b.row));
          chk("beat_ts", 64'(frame_ts_o), 64'(b.ts));
        end
      end
      if (ts_err_o) begin
        err_seen++;
        if (drop_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL drop_unexpected: got ts_err with drop_cnt %0d",
                   drop_cnt_o);
        end else begin
          chk("drop_cnt_at_err", 64'(drop_cnt_o), 64'(drop_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_quiet();
    int n = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("quiet_timeout", 64'(n < 5000), 64'(1));
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    m_flush();
    @(posedge clk);
    #1;
    flush_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, e0, n;
    int unsigned base, ts;
    reset_i = 1'b1;
    flush_i = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(pkt_ready_o), 64'(1));
    chk("rst_fvalid", 64'(frame_valid_o), 64'(0));
    chk("rst_frow", 64'(frame_row_o), 64'(0));
    chk("rst_fidx", 64'(frame_idx_o), 64'(0));
    chk("rst_fts", 64'(frame_ts_o), 64'(0));
    chk("rst_tserr", 64'(ts_err_o), 64'(0));
    chk("rst_dropcnt", 64'(drop_cnt_o), 64'(0));
    reset_i = 1'b0;
    m_reset();

    // ON+OFF on one pixel, then next window closes the frame.
    tx_q.push_back(mk(32'd5, 2, 3, 1'b1));
    tx_q.push_back(mk(32'd9, 2, 3, 1'b0));
    tx_q.push_back(mk(32'd1024, 0, 0, 1'b1));
    wait_quiet();
    do_flush();
    wait_quiet();

    // Late packet in window 1.
    e0 = err_seen;
    tx_q.push_back(mk(32'd1029, 4, 4, 1'b1));
    tx_q.push_back(mk(32'd100, 5, 5, 1'b1));
    wait_quiet();
    chk("late_drop_cnt", 64'(drop_cnt_o), 64'(1));
    chk("late_err_pulses", 64'(err_seen - e0), 64'(1));
    do_flush();
    wait_quiet();

    // Back-pressure while the consumer stalls the drain.
    tx_q.push_back(mk(32'd2048, 1, 1, 1'b1));
    wait_quiet();
    rforce = 1'b0;
    repeat (2) @(posedge clk);
    a0 = acc_cnt;
    for (int i = 0; i < 6; i++)
      tx_q.push_back(mk(32'd3072 + 32'(i * 3), i, 7 - i, i[0]));
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", 64'(acc_cnt - a0), 64'(4));
    chk("bp_ready_low", 64'(pkt_ready_o), 64'(0));
    for (int k = 0; k < 4; k++) begin
      chk("hold_valid", 64'(frame_valid_o), 64'(1));
      chk("hold_idx", 64'(frame_idx_o), 64'(0));
      if (exp_q.size() != 0)
        chk("hold_row", 64'(frame_row_o), 64'(exp_q[0].row));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rforce = 1'b1;
    wait_quiet();
    chk("bp_all_accepted", 64'(acc_cnt - a0), 64'(6));
    do_flush();
    wait_quiet();

    // Flush before the first head is consumed: all-zero frame.
    for (int r = 0; r < 8; r++)
      exp_q.push_back('{idx: 3'(r), row: 16'h0, ts: 32'd5120});
    flush_i = 1'b1;
    tx_q.push_back(mk(32'd5127, 2, 5, 1'b1));
    n = 0;
    while (!frame_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("flush_drain_start", 64'(n < 50), 64'(1));
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    wait_quiet();

    // Reset in the middle of a drain.
    do_flush();
    n = 0;
    while (!(frame_valid_o && frame_idx_o == 3'd3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("row3_reached", 64'(n < 50), 64'(1));
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_fvalid", 64'(frame_valid_o), 64'(0));
    chk("mid_rst_dropcnt", 64'(drop_cnt_o), 64'(0));
    chk("mid_rst_ready", 64'(pkt_ready_o), 64'(1));
    reset_i = 1'b0;
    m_reset();
    tx_q.push_back(mk(32'h300, 3, 4, 1'b1));
    wait_quiet();
    chk("fresh_win_nodrop", 64'(drop_cnt_o), 64'(0));
    do_flush();
    wait_quiet();

    // Timestamp rollover shows up as a late packet.
    tx_q.push_back(mk(32'hFFFF_FFFF, 7, 7, 1'b0));
    tx_q.push_back(mk(32'h0, 0, 0, 1'b1));
    wait_quiet();
    chk("rollover_drop", 64'(drop_cnt_o), 64'(1));
    do_flush();
    wait_quiet();

    // Randomized traffic with random consumer stalls.
    rmode = 1'b1;
    vprob = 60;
    for (int s = 0; s < 4; s++) begin
      base = $urandom_range(0, 1 << 20);
      for (int i = 0; i < 60; i++) begin
        base += $urandom_range(0, 250);
        ts = base;
        if ($urandom_range(9) == 0 && base > 1500)
          ts = base - $urandom_range(1, 1500);
        tx_q.push_back(mk(ts, $urandom_range(7), $urandom_range(7),
                          1'($urandom_range(1))));
      end
      wait_quiet();
      do_flush();
      wait_quiet();
    end

    chk("final_beats_left", 64'(exp_q.size()), 64'(0));
    chk("final_drops_left", 64'(drop_q.size()), 64'(0));
    chk("final_dropcnt", 64'(drop_cnt_o), 64'(m_drops));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
